// File: rtl/core2axi_pkg.sv
// rtl/core2axi_pkg.sv - Shared AXI constants, tracker entry type and lane helper for core2axi_ot
package core2axi_pkg;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   // Lane field is sized for the widest bus (128 bits = four 32-bit lanes).
   typedef struct packed {
      logic       we;
      logic [1:0] lane;
   } txn_entry_t;

   function automatic logic [1:0] lane_sel(input logic [3:0] addr_lo, input int axi_dw);
      logic [1:0] mask;
      mask = 2'((axi_dw / 32) - 1);
      return addr_lo[3:2] & mask;
   endfunction

endpackage

// File: rtl/core2axi_ot_if.sv
// rtl/core2axi_ot_if.sv - AXI4 single-beat master bus bundle used by core2axi_ot
interface core2axi_ot_if #(
   parameter int ADDR_WIDTH     = 32,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int ID_WIDTH       = 4
);
   logic [ID_WIDTH-1:0]         aw_id_o;
   logic [ADDR_WIDTH-1:0]       aw_addr_o;
   logic [7:0]                  aw_len_o;
   logic [2:0]                  aw_size_o;
   logic [1:0]                  aw_burst_o;
   logic [2:0]                  aw_prot_o;
   logic                        aw_valid_o;
   logic                        aw_ready_i;

   logic [AXI_DATA_WIDTH-1:0]   w_data_o;
   logic [AXI_DATA_WIDTH/8-1:0] w_strb_o;
   logic                        w_last_o;
   logic                        w_valid_o;
   logic                        w_ready_i;

   logic [ID_WIDTH-1:0]         b_id_i;
   logic [1:0]                  b_resp_i;
   logic                        b_valid_i;
   logic                        b_ready_o;

   logic [ID_WIDTH-1:0]         ar_id_o;
   logic [ADDR_WIDTH-1:0]       ar_addr_o;
   logic [7:0]                  ar_len_o;
   logic [2:0]                  ar_size_o;
   logic [1:0]                  ar_burst_o;
   logic [2:0]                  ar_prot_o;
   logic                        ar_valid_o;
   logic                        ar_ready_i;

   logic [ID_WIDTH-1:0]         r_id_i;
   logic [AXI_DATA_WIDTH-1:0]   r_data_i;
   logic [1:0]                  r_resp_i;
   logic                        r_last_i;
   logic                        r_valid_i;
   logic                        r_ready_o;

   modport master (
      output aw_id_o, aw_addr_o, aw_len_o, aw_size_o, aw_burst_o, aw_prot_o, aw_valid_o,
      input  aw_ready_i,
      output w_data_o, w_strb_o, w_last_o, w_valid_o,
      input  w_ready_i,
      input  b_id_i, b_resp_i, b_valid_i,
      output b_ready_o,
      output ar_id_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, ar_prot_o, ar_valid_o,
      input  ar_ready_i,
      input  r_id_i, r_data_i, r_resp_i, r_last_i, r_valid_i,
      output r_ready_o
   );

   modport slave (
      input  aw_id_o, aw_addr_o, aw_len_o, aw_size_o, aw_burst_o, aw_prot_o, aw_valid_o,
      output aw_ready_i,
      input  w_data_o, w_strb_o, w_last_o, w_valid_o,
      output w_ready_i,
      output b_id_i, b_resp_i, b_valid_i,
      input  b_ready_o,
      input  ar_id_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, ar_prot_o, ar_valid_o,
      output ar_ready_i,
      output r_id_i, r_data_i, r_resp_i, r_last_i, r_valid_i,
      input  r_ready_o
   );

endinterface

// File: rtl/core2axi_txn_fifo.sv
// rtl/core2axi_txn_fifo.sv - In-order tracker of issued transactions awaiting their R/B response
module core2axi_txn_fifo
   import core2axi_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push,
   input  txn_entry_t       push_entry,
   input  logic             pop,
   output txn_entry_t       head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);
   txn_entry_t       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

endmodule

// File: rtl/core2axi_ot.sv
// rtl/core2axi_ot.sv - Core req/gnt/rvalid data port to AXI4 master with in-order outstanding transactions
module core2axi_ot
   import core2axi_pkg::*;
#(
   parameter int                  ADDR_WIDTH      = 32,
   parameter int                  AXI_DATA_WIDTH  = 32,
   parameter int                  ID_WIDTH        = 4,
   parameter logic [ID_WIDTH-1:0] AXI_ID          = '0,
   parameter int                  MAX_OUTSTANDING = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  data_req_i,
   output logic                  data_gnt_o,
   output logic                  data_rvalid_o,
   input  logic [ADDR_WIDTH-1:0] data_addr_i,
   input  logic                  data_we_i,
   input  logic [3:0]            data_be_i,
   input  logic [31:0]           data_wdata_i,
   output logic [31:0]           data_rdata_o,
   output logic                  data_err_o,
   core2axi_ot_if.master         axi
);
   localparam int LANES  = AXI_DATA_WIDTH / 32;
   localparam int STRB_W = AXI_DATA_WIDTH / 8;
   localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1;

   logic                      ar_pend, aw_pend, w_pend;
   logic [ADDR_WIDTH-1:0]     iss_addr;
   logic [3:0]                iss_be;
   logic [31:0]               iss_wdata;
   logic [1:0]                iss_lane;
   logic                      busy, last_done, stage_free;
   txn_entry_t                push_entry, head;
   logic                      fifo_full, fifo_empty, pop;
   logic [CNT_W-1:0]          track_count;
   logic                      rsp_r, rsp_b;
   logic [AXI_DATA_WIDTH-1:0] r_shift;
   logic                      unused_bits;

   // The stage may take a new request in the same cycle its last pending handshake completes.
   always_comb begin
      busy       = ar_pend | aw_pend | w_pend;
      last_done  = busy & (~ar_pend | axi.ar_ready_i) & (~aw_pend | axi.aw_ready_i)
                        & (~w_pend | axi.w_ready_i);
      stage_free = ~busy | last_done;
   end

   assign data_gnt_o = data_req_i & stage_free & (track_count < CNT_W'(MAX_OUTSTANDING));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ar_pend   <= 1'b0;
         aw_pend   <= 1'b0;
         w_pend    <= 1'b0;
         iss_addr  <= '0;
         iss_be    <= '0;
         iss_wdata <= '0;
      end else begin
         if (ar_pend && axi.ar_ready_i) ar_pend <= 1'b0;
         if (aw_pend && axi.aw_ready_i) aw_pend <= 1'b0;
         if (w_pend && axi.w_ready_i)   w_pend  <= 1'b0;
         if (data_gnt_o) begin
            ar_pend   <= ~data_we_i;
            aw_pend   <= data_we_i;
            w_pend    <= data_we_i;
            iss_addr  <= data_addr_i;
            iss_be    <= data_be_i;
            iss_wdata <= data_wdata_i;
         end
      end
   end

   assign iss_lane       = lane_sel(iss_addr[3:0], AXI_DATA_WIDTH);
   assign axi.aw_id_o    = AXI_ID;
   assign axi.aw_addr_o  = {iss_addr[ADDR_WIDTH-1:2], 2'b00};
   assign axi.aw_len_o   = 8'd0;
   assign axi.aw_size_o  = AXI_SIZE_4B;
   assign axi.aw_burst_o = AXI_BURST_INCR;
   assign axi.aw_prot_o  = 3'b000;
   assign axi.aw_valid_o = aw_pend;
   assign axi.w_data_o   = {LANES{iss_wdata}};
   assign axi.w_strb_o   = STRB_W'(iss_be) << {iss_lane, 2'b00};
   assign axi.w_last_o   = 1'b1;
   assign axi.w_valid_o  = w_pend;
   assign axi.ar_id_o    = AXI_ID;
   assign axi.ar_addr_o  = {iss_addr[ADDR_WIDTH-1:2], 2'b00};
   assign axi.ar_len_o   = 8'd0;
   assign axi.ar_size_o  = AXI_SIZE_4B;
   assign axi.ar_burst_o = AXI_BURST_INCR;
   assign axi.ar_prot_o  = 3'b000;
   assign axi.ar_valid_o = ar_pend;

   assign push_entry = '{we: data_we_i, lane: lane_sel(data_addr_i[3:0], AXI_DATA_WIDTH)};

   core2axi_txn_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tracker (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push       (data_gnt_o),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      (track_count)
   );

   // Only the channel matching the oldest transaction is ever ready, which keeps responses in order.
   assign axi.r_ready_o = ~fifo_empty & ~head.we;
   assign axi.b_ready_o = ~fifo_empty & head.we;
   assign rsp_r         = axi.r_valid_i & axi.r_ready_o;
   assign rsp_b         = axi.b_valid_i & axi.b_ready_o;
   assign pop           = rsp_r | rsp_b;
   assign r_shift       = axi.r_data_i >> {head.lane, 5'b00000};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_rvalid_o <= 1'b0;
         data_rdata_o  <= '0;
         data_err_o    <= 1'b0;
      end else begin
         data_rvalid_o <= pop;
         data_rdata_o  <= rsp_r ? r_shift[31:0] : 32'd0;
         data_err_o    <= rsp_r ? (axi.r_resp_i != AXI_RESP_OKAY) :
                          rsp_b ? (axi.b_resp_i != AXI_RESP_OKAY) : 1'b0;
      end
   end

   assign unused_bits = ^{axi.r_id_i, axi.b_id_i, axi.r_last_i, fifo_full, r_shift, iss_addr};

endmodule

// File: tb/tb_core2axi_ot.sv
// tb/tb_core2axi_ot.sv - Directed bench for core2axi_ot with a queue-based reference model
module tb_core2axi_ot;
   import core2axi_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, gnt, rvalid, we, err;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  be;

   core2axi_ot_if #(.ADDR_WIDTH(32), .AXI_DATA_WIDTH(128), .ID_WIDTH(4)) axi ();

   core2axi_ot #(
      .ADDR_WIDTH(32), .AXI_DATA_WIDTH(128), .ID_WIDTH(4), .AXI_ID(4'd0), .MAX_OUTSTANDING(4)
   ) dut (
      .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_gnt_o(gnt), .data_rvalid_o(rvalid),
      .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
      .data_rdata_o(rdata), .data_err_o(err), .axi(axi)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int grants;

   typedef struct { bit we; logic [31:0] addr; } trk_t;
   trk_t        mq[$];
   bit          m_ar, m_aw, m_w;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_be;
   bit          e_rv, e_err;
   logic [31:0] e_rd;
   bit          chk_en = 1'b0;
   bit          hr, hb, fr, eg;
   logic [15:0] e_strb;
   logic [31:0] rsp_log[$];
   bit          err_log[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int lane_of(input logic [31:0] a);
      return int'(a[3:0]) / 4;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   // Model: check what outputs must be now, then apply what the coming edge will do.
   always @(negedge clk) begin
      if (chk_en) begin
         hr = (mq.size() > 0) && !mq[0].we;
         hb = (mq.size() > 0) && mq[0].we;
         fr = !(m_ar || m_aw || m_w) ||
              ((!m_ar || axi.ar_ready_i) && (!m_aw || axi.aw_ready_i) && (!m_w || axi.w_ready_i));
         eg = req && fr && (mq.size() < 4);
         chk("gnt", gnt, eg);
         chk("ar_valid", axi.ar_valid_o, m_ar);
         chk("aw_valid", axi.aw_valid_o, m_aw);
         chk("w_valid", axi.w_valid_o, m_w);
         chk("aw_const", {axi.aw_id_o, axi.aw_len_o, axi.aw_size_o, axi.aw_burst_o, axi.aw_prot_o},
             {4'd0, 8'd0, 3'b010, 2'b01, 3'b000});
         chk("ar_const", {axi.ar_id_o, axi.ar_len_o, axi.ar_size_o, axi.ar_burst_o, axi.ar_prot_o},
             {4'd0, 8'd0, 3'b010, 2'b01, 3'b000});
         chk("w_last", axi.w_last_o, 1'b1);
         if (m_ar) chk("ar_addr", axi.ar_addr_o, m_addr & ~32'd3);
         if (m_aw) chk("aw_addr", axi.aw_addr_o, m_addr & ~32'd3);
         if (m_w) begin
            e_strb = 16'(m_be) << (4 * lane_of(m_addr));
            chk("w_data", axi.w_data_o, {4{m_wdata}});
            chk("w_strb", axi.w_strb_o, e_strb);
         end
         chk("r_ready", axi.r_ready_o, hr);
         chk("b_ready", axi.b_ready_o, hb);
         chk("rvalid", rvalid, e_rv);
         chk("rdata", rdata, e_rv ? e_rd : 32'd0);
         chk("err", err, e_err);
         if (rvalid) begin
            rsp_log.push_back(rdata);
            err_log.push_back(err);
         end
         if (rst) begin
            mq.delete();
            m_ar = 0; m_aw = 0; m_w = 0;
            e_rv = 0; e_rd = 0; e_err = 0;
         end else begin
            e_rv = 0; e_rd = 0; e_err = 0;
            if (hr && axi.r_valid_i) begin
               e_rv  = 1;
               e_rd  = 32'(axi.r_data_i >> (32 * lane_of(mq[0].addr)));
               e_err = (axi.r_resp_i != 2'b00);
               void'(mq.pop_front());
            end else if (hb && axi.b_valid_i) begin
               e_rv  = 1;
               e_err = (axi.b_resp_i != 2'b00);
               void'(mq.pop_front());
            end
            if (m_ar && axi.ar_ready_i) m_ar = 0;
            if (m_aw && axi.aw_ready_i) m_aw = 0;
            if (m_w && axi.w_ready_i)   m_w  = 0;
            if (eg) begin
               m_ar = !we; m_aw = we; m_w = we;
               m_addr = addr; m_be = be; m_wdata = wdata;
               mq.push_back('{we: we, addr: addr});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; req = 0; we = 0; addr = 0; be = 0; wdata = 0;
      axi.aw_ready_i = 1; axi.w_ready_i = 1; axi.ar_ready_i = 1;
      axi.r_valid_i = 0; axi.b_valid_i = 0; axi.r_data_i = '0; axi.r_resp_i = 0;
      axi.r_id_i = 0; axi.r_last_i = 1; axi.b_id_i = 0; axi.b_resp_i = 0;
      step;
      chk_en = 1;
      at_neg;
      chk("reset_outputs", {gnt, rvalid, rdata, err, axi.ar_valid_o, axi.aw_valid_o,
                            axi.w_valid_o, axi.r_ready_o, axi.b_ready_o}, '0);
      step;
      rst = 0;

      // single read, lane 1 of a 128-bit beat
      req = 1; we = 0; addr = 32'h104; be = 4'hf;
      at_neg; chk("t1_gnt", gnt, 1'b1); step;
      req = 0;
      at_neg; chk("t1_ar_valid", axi.ar_valid_o, 1'b1); chk("t1_ar_addr", axi.ar_addr_o, 32'h104); step;
      axi.r_valid_i = 1; axi.r_data_i = 128'h0000_0000_0000_0000_1111_2222_3333_4444;
      at_neg; chk("t1_r_ready", axi.r_ready_o, 1'b1); step;
      axi.r_valid_i = 0;
      at_neg; chk("t1_rvalid", rvalid, 1'b1); chk("t1_rdata", rdata, 32'h1111_2222); step;

      // write with W accepted three cycles after AW
      rsp_log.delete(); err_log.delete();
      axi.w_ready_i = 0;
      req = 1; we = 1; addr = 32'h108; be = 4'b0011; wdata = 32'hCAFE_F00D;
      at_neg; chk("t2_gnt", gnt, 1'b1); step;
      req = 0; we = 0;
      at_neg; chk("t2_aw_w_valid", {axi.aw_valid_o, axi.w_valid_o}, 2'b11);
      chk("t2_strb", axi.w_strb_o, 16'h0300); step;
      repeat (2) begin
         at_neg; chk("t2_w_wait", {axi.aw_valid_o, axi.w_valid_o}, 2'b01); step;
      end
      axi.w_ready_i = 1;
      at_neg; step;
      axi.b_valid_i = 1; axi.b_resp_i = 2'b00;
      at_neg; chk("t2_b_ready", axi.b_ready_o, 1'b1); step;
      axi.b_valid_i = 0;
      at_neg; chk("t2_rvalid", rvalid, 1'b1); chk("t2_rdata", rdata, 32'd0); step;
      at_neg; chk("t2_pulse_end", rvalid, 1'b0); step;
      chk("t2_pulses", rsp_log.size(), 1);

      // six reads against a tracker of four, responses held back
      rsp_log.delete(); err_log.delete();
      grants = 0;
      for (int c = 0; c < 10; c++) begin
         req = (grants < 6); we = 0; addr = 32'h200 + 4 * grants;
         at_neg; if (gnt) grants++; step;
      end
      chk("t3_grants_blocked", grants, 4);
      axi.r_valid_i = 1; axi.r_data_i = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
      for (int c = 0; c < 20 && rsp_log.size() < 6; c++) begin
         req = (grants < 6); we = 0; addr = 32'h200 + 4 * grants;
         at_neg;
         if (c == 0) chk("t3_no_bypass", gnt, 1'b0);
         if (c == 1) chk("t3_regrant", gnt, 1'b1);
         if (gnt) grants++;
         step;
      end
      req = 0; axi.r_valid_i = 0;
      chk("t3_grants_total", grants, 6);
      chk("t3_responses", rsp_log.size(), 6);

      // R, W, R with both response channels valid together; write gets SLVERR
      rsp_log.delete(); err_log.delete();
      req = 1; we = 0; addr = 32'h300;
      at_neg; chk("t4_gnt0", gnt, 1'b1); step;
      we = 1; addr = 32'h304; be = 4'hf; wdata = 32'hDEAD_BEEF;
      at_neg; chk("t4_gnt1", gnt, 1'b1); step;
      we = 0; addr = 32'h308;
      at_neg; chk("t4_gnt2", gnt, 1'b1); step;
      req = 0;
      axi.r_valid_i = 1; axi.b_valid_i = 1; axi.b_resp_i = 2'b10;
      axi.r_data_i = 128'h44444444_33333333_22222222_11111111;
      at_neg; chk("t4_readies0", {axi.r_ready_o, axi.b_ready_o}, 2'b10); step;
      at_neg; chk("t4_rsp0", {rvalid, rdata, err}, {1'b1, 32'h1111_1111, 1'b0});
      chk("t4_readies1", {axi.r_ready_o, axi.b_ready_o}, 2'b01); step;
      at_neg; chk("t4_rsp1", {rvalid, rdata, err}, {1'b1, 32'h0, 1'b1}); step;
      axi.r_valid_i = 0; axi.b_valid_i = 0; axi.b_resp_i = 2'b00;
      at_neg; chk("t4_rsp2", {rvalid, rdata, err}, {1'b1, 32'h3333_3333, 1'b0}); step;
      chk("t4_order", {rsp_log.size(), err_log.size()}, {32'd3, 32'd3});

      // reset with three reads outstanding
      for (int i = 0; i < 3; i++) begin
         req = 1; we = 0; addr = 32'h400 + 4 * i;
         at_neg; step;
      end
      req = 0; rst = 1;
      at_neg; step;
      rst = 0;
      at_neg;
      chk("t6_cleared", {gnt, rvalid, rdata, err, axi.ar_valid_o, axi.aw_valid_o,
                         axi.w_valid_o, axi.r_ready_o, axi.b_ready_o}, '0);
      step;
      req = 1; we = 0; addr = 32'h40C;
      at_neg; chk("t6_gnt", gnt, 1'b1); step;
      req = 0;
      at_neg; chk("t6_ar", {axi.ar_valid_o, axi.ar_addr_o}, {1'b1, 32'h40C}); step;
      axi.r_valid_i = 1; axi.r_data_i = 128'h99999999_88888888_77777777_66666666;
      at_neg; step;
      axi.r_valid_i = 0;
      at_neg; chk("t6_rsp", {rvalid, rdata}, {1'b1, 32'h9999_9999}); step;

      repeat (3) step;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/core2axi_ot.md
# core2axi_ot

Core-to-AXI4 master bridge for the core's data port (req/gnt/rvalid protocol), successor to the single-transaction bridge. Supports up to MAX_OUTSTANDING in-flight single-beat transactions, an AXI data bus wider than the 32-bit core word, and an error flag. Responses return to the core in request order. Sits between the core LSU and the AXI interconnect.

## Interface
- ADDR_WIDTH, 32: address width, core and AXI.
- AXI_DATA_WIDTH, 32: AXI data width; legal values are 32, 64 and 128. Core word is fixed at 32.
- ID_WIDTH, 4: AXI ID width.
- AXI_ID, 0: constant ID driven on AW and AR.
- MAX_OUTSTANDING, 4: in-flight transaction limit; power of two, 2..16.
- clk_i  in  1  clock; one clock, all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- data_req_i / data_gnt_o / data_rvalid_o  in/out/out  1  core handshake.
- data_addr_i  in  ADDR_WIDTH  byte address.
- data_we_i  in  1  1 = write.
- data_be_i  in  4  byte enables.
- data_wdata_i  in  32  write data.
- data_rdata_o  out  32  read data.
- data_err_o  out  1  response error, valid with data_rvalid_o.
- aw_id_o, aw_addr_o, aw_len_o[7:0], aw_size_o[2:0], aw_burst_o[1:0], aw_prot_o[2:0], aw_valid_o  out; aw_ready_i  in.
- w_data_o[AXI_DATA_WIDTH], w_strb_o[AXI_DATA_WIDTH/8], w_last_o, w_valid_o  out; w_ready_i  in.
- b_id_i, b_resp_i[1:0], b_valid_i  in; b_ready_o  out.
- ar_* mirrors aw_*; r_id_i, r_data_i[AXI_DATA_WIDTH], r_resp_i, r_last_i, r_valid_i  in; r_ready_o  out.

## Operation
- Constant outputs: len=0, size=3'b010, burst=INCR (2'b01), prot=0, w_last_o=1. aw_addr_o and ar_addr_o carry the request address with bits [1:0] forced to 0.
- Lane select: lane = addr[log2(AXI_DATA_WIDTH/8)-1:2]; the lane is 0-wide when AXI_DATA_WIDTH is 32.
  - Write: w_data_o = wdata replicated across all lanes; w_strb_o = be << (4*lane).
  - Read: data_rdata_o = r_data_i[32*lane +: 32].
- Issue stage: one register holding {we, addr, be, wdata}.
  - data_gnt_o = data_req_i & issue stage free & track_count < MAX_OUTSTANDING. It is combinational.
  - There is no same-cycle pop bypass: a full tracker blocks the grant even when a response retires in that cycle.
  - The issue stage is free when empty, or when its last pending handshake completes in the current cycle.
- On grant, the request loads the issue stage and {we, lane} is pushed into the tracker FIFO.
- Read issue: ar_valid_o held until ar_ready_i.
- Write issue: aw_valid_o and w_valid_o rise together. Each drops independently on its own ready. The stage frees once both handshakes have completed.
- Retire at the head of the tracker:
  - Head is a read: r_ready_o=1, b_ready_o=0.
  - Head is a write: b_ready_o=1, r_ready_o=0.
  - Tracker empty: both readies are 0.
- On the accepted beat, pop the tracker and register the response.
  - data_rvalid_o=1.
  - data_rdata_o = selected lane for a read, 0 for a write.
  - data_err_o = (resp != OKAY).
- r_valid_i and b_valid_i in the same cycle: only the head type is consumed; the other waits.
- The R/B ID is ignored. In-order completion per channel is guaranteed by the single constant ID.

## Timing
- Reset: all valids, readies, data_rvalid_o and data_err_o are 0; data_rdata_o is 0; issue stage and tracker are cleared.
- Reset mid-operation discards in-flight transactions. The slave must be reset in the same cycle.
- Read, minimum latency:
  - gnt in cycle 0.
  - ar_valid_o in cycle 1 (accepted if ar_ready_i=1).
  - Earliest r_valid_i in cycle 2.
  - data_rvalid_o in cycle 3.
- Write, minimum latency: gnt c0, aw/w valid c1, b_valid_i c2, data_rvalid_o c3.
- Back-to-back throughput: one grant per cycle while readies stay high and the tracker is not full.
- data_rvalid_o is a one-cycle pulse per response. The core cannot stall responses.
- AXI valids never drop before their ready; address, data and strobes stay stable while valid.

## Structure
- Package core2axi_pkg: AXI_BURST_INCR, AXI_SIZE_4B, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR, and the tracker entry struct {we, lane}.
- Sub-module core2axi_txn_fifo: synchronous FIFO of tracker entries, depth MAX_OUTSTANDING.
  - Ports: push, pop, full, empty, count.
  - Simultaneous push and pop keep the count unchanged.
  - Pointers wrap modulo depth.

## Test plan
- Single read, AXI_DATA_WIDTH=64, addr 0x104, r_data 0x11112222_33334444 -> ar_addr 0x104, data_rdata_o 0x11112222 in cycle 3.
- Write at addr 0x108, be 4'b0011, AXI_DATA_WIDTH=128, w_ready delayed 3 cycles after aw_ready -> w_strb 16'h0300, one data_rvalid_o pulse after b_valid_i.
- MAX_OUTSTANDING=4, 6 back-to-back reads with r_valid_i held low -> 4 grants, then data_gnt_o=0 until the first R beat; then the remaining 2 are granted.
- Interleave R, W, R with b_valid_i and r_valid_i asserted together -> responses delivered in request order, each one cycle after its own channel handshake.
- b_resp=2'b10 on a write -> data_err_o=1 with data_rvalid_o, data_rdata_o=0.
- rst_i asserted with 3 transactions in flight -> next cycle all outputs 0, track count 0; a new request is granted in the following cycle.
